// File: rtl/collision_event_manager.sv
// collision_event_manager
// Collects per-pixel projectile/banana/ship collision strobes over a frame and
// turns them into single registered event pulses at the next frame boundary.
// Also owns the lives counter, the post-hit invulnerability window and the
// IDLE / PLAY / INVULN / GAME_OVER state machine.
module collision_event_manager #(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       game_start,
  input  logic       collision,
  input  logic       collisionBanana,
  input  logic       drawing_request_spaceship,
  input  logic       drawing_request_banana,
  output logic       projectile_done,
  output logic       banana_done,
  output logic       ship_hit,
  output logic [2:0] lives,
  output logic       invulnerable,
  output logic       game_over,
  output logic       playing
);

  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic       proj_seen_q, proj_seen_d;
  logic       ban_seen_q, ban_seen_d;
  logic       ship_seen_q, ship_seen_d;
  logic       projectile_done_q, projectile_done_d;
  logic       banana_done_q, banana_done_d;
  logic       ship_hit_q, ship_hit_d;

  logic       ship_px;

  assign ship_px = drawing_request_spaceship & drawing_request_banana;

  // Next-state, frame latches, lives/invulnerability bookkeeping and pulses
  always_comb begin
    state_d           = state_q;
    lives_d           = lives_q;
    inv_cnt_d         = inv_cnt_q;
    projectile_done_d = 1'b0;
    banana_done_d     = 1'b0;
    ship_hit_d        = 1'b0;

    // A frame boundary closes the old frame; that cycle's strobes open the new one
    if (startOfFrame) begin
      proj_seen_d = collision;
      ban_seen_d  = collisionBanana;
      ship_seen_d = ship_px;
    end else begin
      proj_seen_d = proj_seen_q | collision;
      ban_seen_d  = ban_seen_q  | collisionBanana;
      ship_seen_d = ship_seen_q | ship_px;
    end

    case (state_q)
      IDLE, GAME_OVER: begin
        if (game_start) begin
          state_d     = PLAY;
          lives_d     = LIVES_LOAD;
          // Discard anything collected before the game began
          proj_seen_d = collision;
          ban_seen_d  = collisionBanana;
          ship_seen_d = ship_px;
        end
      end
      PLAY: begin
        if (startOfFrame) begin
          projectile_done_d = proj_seen_q;
          banana_done_d     = ban_seen_q;
          if (ship_seen_q && (lives_q != 3'd0)) begin
            ship_hit_d = 1'b1;
            lives_d    = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d = GAME_OVER;
            end else begin
              state_d   = INVULN;
              inv_cnt_d = INV_LOAD;
            end
          end
        end
      end
      INVULN: begin
        if (startOfFrame) begin
          projectile_done_d = proj_seen_q;
          banana_done_d     = ban_seen_q;
          // Ship overlaps are ignored while the window is open
          if (inv_cnt_q <= 8'd1) begin
            inv_cnt_d = 8'd0;
            state_d   = PLAY;
          end else begin
            inv_cnt_d = inv_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      lives_q           <= 3'd0;
      inv_cnt_q         <= 8'd0;
      proj_seen_q       <= 1'b0;
      ban_seen_q        <= 1'b0;
      ship_seen_q       <= 1'b0;
      projectile_done_q <= 1'b0;
      banana_done_q     <= 1'b0;
      ship_hit_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      lives_q           <= lives_d;
      inv_cnt_q         <= inv_cnt_d;
      proj_seen_q       <= proj_seen_d;
      ban_seen_q        <= ban_seen_d;
      ship_seen_q       <= ship_seen_d;
      projectile_done_q <= projectile_done_d;
      banana_done_q     <= banana_done_d;
      ship_hit_q        <= ship_hit_d;
    end
  end

  assign projectile_done = projectile_done_q;
  assign banana_done     = banana_done_q;
  assign ship_hit        = ship_hit_q;
  assign lives           = lives_q;
  assign invulnerable    = (state_q == INVULN);
  assign game_over       = (state_q == GAME_OVER);
  assign playing         = (state_q == PLAY) || (state_q == INVULN);

endmodule

// File: tb/tb_collision_event_manager.sv
// Testbench for collision_event_manager: directed scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_collision_event_manager;

  localparam int LIV = 3;
  localparam int INV = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0, gs = 1'b0, col = 1'b0, colb = 1'b0, dsp = 1'b0, dban = 1'b0;
  logic       projectile_done, banana_done, ship_hit;
  logic [2:0] lives;
  logic       invulnerable, game_over, playing;

  int checks = 0;
  int errors = 0;

  // Reference model: game mode, lives, frames left in the window, frame flags
  localparam int M_IDLE = 0, M_PLAY = 1, M_INV = 2, M_OVER = 3;
  int m_mode, m_lives, m_left;
  bit f_proj, f_ban, f_ship;
  bit m_pd, m_bd, m_sh;

  collision_event_manager #(.LIVES_INIT(LIV), .INVULN_FRAMES(INV)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .startOfFrame              (sof),
    .game_start                (gs),
    .collision                 (col),
    .collisionBanana           (colb),
    .drawing_request_spaceship (dsp),
    .drawing_request_banana    (dban),
    .projectile_done           (projectile_done),
    .banana_done               (banana_done),
    .ship_hit                  (ship_hit),
    .lives                     (lives),
    .invulnerable              (invulnerable),
    .game_over                 (game_over),
    .playing                   (playing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = 0; m_left = 0;
    f_proj = 0; f_ban = 0; f_ship = 0;
    m_pd = 0; m_bd = 0; m_sh = 0;
  endtask

  // One clock edge of the game rules, using the inputs currently driven
  task automatic model_edge();
    bit overlap;
    overlap = dsp && dban;
    m_pd = 0; m_bd = 0; m_sh = 0;
    if ((m_mode == M_IDLE || m_mode == M_OVER) && gs) begin
      m_mode = M_PLAY; m_lives = LIV;
      f_proj = col; f_ban = colb; f_ship = overlap;
    end else if (sof) begin
      if (m_mode == M_PLAY || m_mode == M_INV) begin
        m_pd = f_proj; m_bd = f_ban;
      end
      if (m_mode == M_PLAY && f_ship) begin
        m_sh = 1;
        m_lives = m_lives - 1;
        if (m_lives == 0) m_mode = M_OVER;
        else begin m_mode = M_INV; m_left = INV; end
      end else if (m_mode == M_INV) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_PLAY;
      end
      f_proj = col; f_ban = colb; f_ship = overlap;
    end else begin
      f_proj |= col; f_ban |= colb; f_ship |= overlap;
    end
  endtask

  task automatic check_all();
    check_eq("projectile_done", {7'd0, projectile_done}, {7'd0, m_pd});
    check_eq("banana_done", {7'd0, banana_done}, {7'd0, m_bd});
    check_eq("ship_hit", {7'd0, ship_hit}, {7'd0, m_sh});
    check_eq("lives", {5'd0, lives}, 8'(m_lives));
    check_eq("invulnerable", {7'd0, invulnerable}, {7'd0, m_mode == M_INV});
    check_eq("game_over", {7'd0, game_over}, {7'd0, m_mode == M_OVER});
    check_eq("playing", {7'd0, playing}, {7'd0, m_mode == M_PLAY || m_mode == M_INV});
  endtask

  task automatic step(input bit s, input bit g, input bit c, input bit cb, input bit ds, input bit db);
    sof = s; gs = g; col = c; colb = cb; dsp = ds; dban = db;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sof_step();
    step(1, 0, 0, 0, 0, 0);
  endtask

  // Frame body: first nc cycles projectile hits, first nb banana hits, first ns ship overlaps
  task automatic body(input int len, input int nc, input int nb, input int ns);
    for (int i = 0; i < len; i++)
      step(0, 0, i < nc, (i < nb) || (i < ns), i < ns, i < ns);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Start game, then five quiet frames
    step(0, 1, 0, 0, 0, 0);
    check_eq("lives_start", {5'd0, lives}, 8'd3);
    check_eq("playing_start", {7'd0, playing}, 8'd1);
    repeat (5) begin sof_step(); quiet(9); end

    // 40 projectile-collision pixels give one pulse only
    body(45, 40, 0, 0);
    sof_step();
    check_eq("proj_pulse", {7'd0, projectile_done}, 8'd1);
    quiet(1);
    check_eq("proj_one_cycle", {7'd0, projectile_done}, 8'd0);
    quiet(8);
    sof_step();
    check_eq("proj_next_frame", {7'd0, projectile_done}, 8'd0);
    quiet(9);

    // Banana over ship: hit, then invulnerability for exactly INV boundaries
    body(12, 0, 0, 10);
    sof_step();
    check_eq("hit_banana", {7'd0, banana_done}, 8'd1);
    check_eq("hit_ship", {7'd0, ship_hit}, 8'd1);
    check_eq("hit_lives", {5'd0, lives}, 8'd2);
    check_eq("hit_invuln", {7'd0, invulnerable}, 8'd1);
    for (int b = 1; b <= 4; b++) begin quiet(9); sof_step(); end
    body(12, 0, 0, 5);
    sof_step();
    check_eq("inv_banana", {7'd0, banana_done}, 8'd1);
    check_eq("inv_no_hit", {7'd0, ship_hit}, 8'd0);
    check_eq("inv_lives", {5'd0, lives}, 8'd2);
    for (int b = 6; b <= INV; b++) begin
      quiet(5);
      sof_step();
      if (b == INV - 1) check_eq("inv_last_frame", {7'd0, invulnerable}, 8'd1);
      if (b == INV) check_eq("inv_end", {7'd0, invulnerable}, 8'd0);
    end

    // Remaining two hits lead to game over
    body(8, 0, 0, 3);
    sof_step();
    check_eq("lives_1", {5'd0, lives}, 8'd1);
    repeat (INV) begin quiet(5); sof_step(); end
    body(8, 0, 0, 3);
    sof_step();
    check_eq("lives_0", {5'd0, lives}, 8'd0);
    check_eq("over_flag", {7'd0, game_over}, 8'd1);
    check_eq("over_playing", {7'd0, playing}, 8'd0);
    body(12, 5, 5, 5);
    sof_step();
    check_eq("over_no_pulse", {5'd0, projectile_done, banana_done, ship_hit}, 8'd0);
    step(0, 1, 0, 0, 0, 0);
    check_eq("restart_lives", {5'd0, lives}, 8'd3);
    check_eq("restart_playing", {7'd0, playing}, 8'd1);

    // Collision only in the boundary cycle counts toward the next frame
    quiet(5);
    step(1, 0, 1, 0, 0, 0);
    check_eq("sof_col_not_closing", {7'd0, projectile_done}, 8'd0);
    quiet(5);
    sof_step();
    check_eq("sof_col_next", {7'd0, projectile_done}, 8'd1);
    quiet(3);

    // Reset during INVULN with 12 frames left
    body(8, 0, 0, 3);
    sof_step();
    repeat (INV - 12) begin quiet(3); sof_step(); end
    quiet(2);
    async_reset();
    check_eq("rst_lives", {5'd0, lives}, 8'd0);
    check_eq("rst_invuln", {7'd0, invulnerable}, 8'd0);
    quiet(2);
    step(0, 1, 0, 0, 0, 0);
    check_eq("rst_restart_lives", {5'd0, lives}, 8'd3);
    check_eq("rst_restart_invuln", {7'd0, invulnerable}, 8'd0);

    // Randomized frames, including coincident start/boundary and stray resets
    for (int f = 0; f < 250; f++) begin
      int len;
      len = $urandom_range(6, 14);
      for (int i = 0; i < len; i++) begin
        if (($urandom % 500) == 0) async_reset();
        step(i == 0, ($urandom % 30) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
             ($urandom % 4) == 0, ($urandom % 4) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
